// File: rtl/and_or_rr_arbiter.sv
// Round-robin arbiter sharing one registered (a & b) | c unit among N_REQ requesters.
// Each operation runs IDLE -> EXEC -> DONE, returning the result with a one-cycle ack.
module and_or_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*WIDTH-1:0]       op_a,
    input  logic [N_REQ*WIDTH-1:0]       op_b,
    input  logic [N_REQ*WIDTH-1:0]       op_c,
    output logic [N_REQ-1:0]             gnt,
    output logic [N_REQ-1:0]             ack,
    output logic [WIDTH-1:0]             result,
    output logic [$clog2(N_REQ)-1:0]     result_id,
    output logic                         busy
);
    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [IDW-1:0]     rid_q, rid_d;
    logic               busy_q, busy_d;
    logic [IDW-1:0]     last_q, last_d;
    logic [IDW-1:0]     win_q, win_d;
    logic [WIDTH-1:0]   a_q, b_q, c_q;

    logic               found;
    logic [IDW-1:0]     win_idx;
    logic [IDW:0]       sum;
    logic [IDW-1:0]     cand;
    logic [WIDTH-1:0]   a_sel, b_sel, c_sel;

    // Winner search: first set req bit starting at last+1, wrapping at N_REQ.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        sum     = '0;
        cand    = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            sum = {1'b0, last_q} + (IDW+1)'(off);
            if (sum >= (IDW+1)'(N_REQ)) begin
                sum = sum - (IDW+1)'(N_REQ);
            end
            cand = sum[IDW-1:0];
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        c_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == IDW'(i)) begin
                a_sel = op_a[i*WIDTH +: WIDTH];
                b_sel = op_b[i*WIDTH +: WIDTH];
                c_sel = op_c[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        result_d = result_q;
        rid_d    = rid_q;
        busy_d   = busy_q;
        last_d   = last_q;
        win_d    = win_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    win_d          = win_idx;
                    busy_d         = 1'b1;
                    state_d        = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = (a_q & b_q) | c_q;
                rid_d    = win_q;
                ack_d    = gnt_q;
                last_d   = win_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            ack_q    <= '0;
            result_q <= '0;
            rid_q    <= '0;
            busy_q   <= 1'b0;
            last_q   <= IDW'(N_REQ - 1);
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            result_q <= result_d;
            rid_q    <= rid_d;
            busy_q   <= busy_d;
            last_q   <= last_d;
            win_q    <= win_d;
        end
    end

    // Operands are only meaningful after a grant, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && found) begin
            a_q <= a_sel;
            b_q <= b_sel;
            c_q <= c_sel;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign result    = result_q;
    assign result_id = rid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_and_or_rr_arbiter.sv
// Scoreboard bench for and_or_rr_arbiter: directed stimulus pushes expected
// (id, result) pairs; a negedge monitor pops and compares on every ack.
`timescale 1ns/1ps
module tb_and_or_rr_arbiter;
    localparam int N = 4;
    localparam int W = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] op_a, op_b, op_c;
    logic [N-1:0] gnt, ack;
    logic [W-1:0] result;
    logic [1:0]   result_id;
    logic         busy;

    and_or_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .gnt(gnt), .ack(ack), .result(result),
        .result_id(result_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [W-1:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
        end
    endtask

    task automatic push(input int id, input logic [W-1:0] res);
        exp_t e;
        e.id  = id;
        e.res = res;
        exp_q.push_back(e);
    endtask

    // Monitor: every ack must match the oldest expected transaction.
    always @(negedge clk) begin
        if (mon_en && ack !== '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_ack_onehot", 32'(ack), 32'(1) << e.id);
                chk("sb_result_id", 32'(result_id), 32'(e.id));
                chk("sb_result", 32'(result), 32'(e.res));
            end
        end
    end

    task automatic wait_ack(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (|ack) begin
                got = 1'b1;
                break;
            end
        end
        chk(name, 32'(got), 32'd1);
    endtask

    // Drives one request mask from IDLE and waits for its ack, then drops req.
    task automatic run_op(input logic [N-1:0] rq, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] c, input int win, input logic [W-1:0] res,
                          input string name);
        @(negedge clk);
        op_a = a; op_b = b; op_c = c;
        push(win, res);
        req = rq;
        wait_ack(name);
        req = '0;
    endtask

    localparam logic [7:0] TT = 8'b1110_1010;  // result for abc = 7..0

    initial begin
        logic [31:0] t_prev;
        bit          got;
        rst_n = 1'b0; req = '0; op_a = '0; op_b = '0; op_c = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_gnt", 32'(gnt), 32'd0);
            chk("idle_ack", 32'(ack), 32'd0);
            chk("idle_result", 32'(result), 32'd0);
            chk("idle_rid", 32'(result_id), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Round robin from reset: 0,1,2,3,0 with 3-cycle spacing; result = a bit
        @(negedge clk);
        op_a = 4'b0101; op_b = 4'b1111; op_c = 4'b0000;
        push(0, 1'b1); push(1, 1'b0); push(2, 1'b1); push(3, 1'b0); push(0, 1'b1);
        req = 4'b1111;
        t_prev = 0;
        for (int n = 0; n < 5; n++) begin
            got = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (|ack) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("rr_ack_seen", 32'(got), 32'd1);
            if (n > 0) chk("rr_spacing", 32'($time) - t_prev, 32'd30);
            t_prev = 32'($time);
            req = req & ~ack;
            if (n < 4) begin
                @(negedge clk);
                req = 4'b1111;
            end
        end
        req = '0;

        // Wrap priority
        run_op(4'b1000, 4'b1000, 4'b1000, 4'b0000, 3, 1'b1, "wrap_g3");
        run_op(4'b0011, 4'b0001, 4'b0000, 4'b0000, 0, 1'b0, "wrap_after3");
        run_op(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 1'b1, "wrap_g1");
        run_op(4'b1001, 4'b1000, 4'b1000, 4'b0000, 3, 1'b1, "wrap_after1");

        // Single request with latency checks
        @(negedge clk);
        op_a = 4'b0100; op_b = 4'b0100; op_c = 4'b0000;
        push(2, 1'b1);
        req = 4'b0100;
        @(negedge clk);
        chk("lat_gnt_k", 32'(gnt), 32'h4);
        chk("lat_busy_k", 32'(busy), 32'd1);
        chk("lat_ack_k", 32'(ack), 32'd0);
        @(negedge clk);
        chk("lat_ack_k1", 32'(ack), 32'h4);
        chk("lat_gnt_k1", 32'(gnt), 32'h4);
        req = '0;
        @(negedge clk);
        chk("lat_busy_k2", 32'(busy), 32'd0);
        chk("lat_gnt_k2", 32'(gnt), 32'd0);
        chk("lat_ack_k2", 32'(ack), 32'd0);

        // Truth table through requester 0
        for (int v = 0; v < 8; v++) begin
            logic [2:0] abc;
            abc = 3'(v);
            run_op(4'b0001, {3'b000, abc[2]}, {3'b000, abc[1]}, {3'b000, abc[0]},
                   0, TT[v], "tt_ack");
        end

        // Mid-op disturbance: op_c and req change in EXEC
        @(negedge clk);
        op_a = 4'b0000; op_b = 4'b0000; op_c = 4'b0001;
        push(0, 1'b1);
        req = 4'b0001;
        @(negedge clk);
        chk("mid_gnt", 32'(gnt), 32'h1);
        op_c = 4'b0000; req = '0;
        wait_ack("mid_ack");

        // Reset during EXEC: no ack, everything cleared
        @(negedge clk);
        op_a = 4'b0010; op_b = 4'b0010; op_c = 4'b0000;
        req = 4'b0010;
        @(negedge clk);
        chk("rstx_gnt", 32'(gnt), 32'h2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstx_gnt0", 32'(gnt), 32'd0);
        chk("rstx_ack0", 32'(ack), 32'd0);
        chk("rstx_result0", 32'(result), 32'd0);
        chk("rstx_rid0", 32'(result_id), 32'd0);
        chk("rstx_busy0", 32'(busy), 32'd0);
        rst_n = 1'b1; req = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstx_no_ack", 32'(ack), 32'd0);
        end
        // Pointer back to N-1: requester 0 wins over 3
        run_op(4'b1001, 4'b0001, 4'b0001, 4'b0000, 0, 1'b1, "rstx_ptr");

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
